// File: rtl/uart_component.sv
`default_nettype none
// ============================================================================
// Module   : uart_component
// Brief    : Memory-mapped 8N1 UART with register file and level interrupt.
//            Define UART_LOOPBACK_EN to feed the transmitter into the receiver.
// Revision : 1.0 - initial release
// ============================================================================
module uart_component #(
  parameter int BAUD_DIV = 104
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cs,
  input  logic       rd,
  input  logic       wr,
  input  logic [2:0] addr,
  input  logic [7:0] in_data,
  output logic [7:0] out_data,
  input  logic       rx_in,
  output logic       tx_out,
  output logic       irq,
  output logic [2:0] irq_id
);

  localparam int                c_cnt_w     = $clog2(BAUD_DIV);
  localparam logic [c_cnt_w-1:0] c_bit_last  = c_cnt_w'(BAUD_DIV - 1);
  localparam logic [c_cnt_w-1:0] c_half_last = c_cnt_w'(BAUD_DIV / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // Bus decode; a simultaneous write suppresses the read.
  logic w_wr_acc, w_rd_acc, w_rd_first, r_prev_rd;
  logic w_wr_ctrl, w_wr_stat, w_wr_txd, w_wr_scr;

  assign w_wr_acc   = !cs && !wr;
  assign w_rd_acc   = !cs && !rd && wr;
  assign w_rd_first = w_rd_acc && !r_prev_rd;
  assign w_wr_ctrl  = w_wr_acc && (addr == 3'd0);
  assign w_wr_stat  = w_wr_acc && (addr == 3'd1);
  assign w_wr_txd   = w_wr_acc && (addr == 3'd3);
  assign w_wr_scr   = w_wr_acc && (addr == 3'd4);

  logic [2:0] r_ctrl;
  logic [7:0] r_rx_data, r_scratch, r_out_data;
  logic       r_rx_avail, r_overrun, r_frame_err, r_tx_done;
  logic       r_irq;
  logic [2:0] r_irq_id;

  // ---------------------------------------------------------------- transmitter
  tx_state_t          r_tx_state, w_tx_next;
  logic [c_cnt_w-1:0] r_tx_cnt;
  logic [2:0]         r_tx_bit;
  logic [7:0]         r_tx_shift, r_tx_data;
  logic               r_tx_line, w_tx_line, w_tx_busy, w_tx_go, w_tx_adv, w_tx_finish;

  assign w_tx_busy   = (r_tx_state != TX_IDLE);
  assign w_tx_go     = w_wr_txd && !w_tx_busy;
  assign w_tx_adv    = (r_tx_cnt == c_bit_last);
  assign w_tx_finish = (r_tx_state == TX_STOP) && w_tx_adv;

  always_comb begin
    w_tx_next = r_tx_state;
    w_tx_line = 1'b1;
    case (r_tx_state)
      TX_IDLE:  if (w_tx_go) w_tx_next = TX_START;
      TX_START: begin
        w_tx_line = 1'b0;
        if (w_tx_adv) w_tx_next = TX_DATA;
      end
      TX_DATA: begin
        w_tx_line = r_tx_shift[0];
        if (w_tx_adv && (r_tx_bit == 3'd7)) w_tx_next = TX_STOP;
      end
      TX_STOP:  if (w_tx_adv) w_tx_next = TX_IDLE;
      default:  w_tx_next = TX_IDLE;
    endcase
  end

  // The line is registered, so it trails the state by one cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= 3'd0;
      r_tx_shift <= 8'h00;
      r_tx_data  <= 8'h00;
      r_tx_line  <= 1'b1;
    end else begin
      r_tx_state <= w_tx_next;
      r_tx_line  <= w_tx_line;
      if ((r_tx_state == TX_IDLE) || w_tx_adv) r_tx_cnt <= '0;
      else                                     r_tx_cnt <= r_tx_cnt + 1'b1;
      if (w_tx_go) begin
        r_tx_shift <= in_data;
        r_tx_data  <= in_data;
        r_tx_bit   <= 3'd0;
      end else if ((r_tx_state == TX_DATA) && w_tx_adv) begin
        r_tx_shift <= {1'b0, r_tx_shift[7:1]};
        r_tx_bit   <= r_tx_bit + 3'd1;
      end
    end
  end

  // ------------------------------------------------------------------- receiver
  logic w_rx_src;
`ifdef UART_LOOPBACK_EN
  assign w_rx_src = r_tx_line;
  assign tx_out   = 1'b1;
`else
  assign w_rx_src = rx_in;
  assign tx_out   = r_tx_line;
`endif

  rx_state_t          r_rx_state, w_rx_next;
  logic [1:0]         r_rx_sync;
  logic               r_rx_prev, w_rx_bit, w_rx_adv;
  logic [c_cnt_w-1:0] r_rx_cnt;
  logic [2:0]         r_rx_bit;
  logic [7:0]         r_rx_shift;
  logic               w_rx_done, w_rx_clear, w_rx_load, w_rx_ovr, w_rx_ferr;

  assign w_rx_bit = r_rx_sync[1];
  assign w_rx_adv = (r_rx_state == RX_START) ? (r_rx_cnt == c_half_last)
                                             : (r_rx_cnt == c_bit_last);

  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      RX_IDLE:  if (r_rx_prev && !w_rx_bit) w_rx_next = RX_START;
      RX_START: if (w_rx_adv) w_rx_next = w_rx_bit ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_rx_adv && (r_rx_bit == 3'd7)) w_rx_next = RX_STOP;
      RX_STOP:  if (w_rx_adv) w_rx_next = RX_IDLE;
      default:  w_rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rx_sync  <= 2'b11;
      r_rx_prev  <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= 3'd0;
      r_rx_shift <= 8'h00;
    end else begin
      r_rx_sync  <= {r_rx_sync[0], w_rx_src};
      r_rx_prev  <= w_rx_bit;
      r_rx_state <= w_rx_next;
      if ((r_rx_state == RX_IDLE) || w_rx_adv) r_rx_cnt <= '0;
      else                                     r_rx_cnt <= r_rx_cnt + 1'b1;
      if (r_rx_state == RX_IDLE) begin
        r_rx_bit <= 3'd0;
      end else if ((r_rx_state == RX_DATA) && w_rx_adv) begin
        r_rx_shift <= {w_rx_bit, r_rx_shift[7:1]};
        r_rx_bit   <= r_rx_bit + 3'd1;
      end
    end
  end

  // A byte completing in the same cycle as a read/flush is accepted, not overrun.
  assign w_rx_done  = (r_rx_state == RX_STOP) && w_rx_adv;
  assign w_rx_clear = (w_rd_first && (addr == 3'd2)) || (w_wr_ctrl && in_data[3]);
  assign w_rx_ferr  = w_rx_done && !w_rx_bit;
  assign w_rx_load  = w_rx_done && w_rx_bit && (!r_rx_avail || w_rx_clear);
  assign w_rx_ovr   = w_rx_done && w_rx_bit && r_rx_avail && !w_rx_clear;

  // -------------------------------------------------------------- register file
  logic [7:0] w_rd_mux;

  always_comb begin
    w_rd_mux = 8'h00;
    case (addr)
      3'd0:    w_rd_mux = {5'b0, r_ctrl};
      3'd1:    w_rd_mux = {3'b0, r_tx_done, r_frame_err, r_overrun, w_tx_busy, r_rx_avail};
      3'd2:    w_rd_mux = r_rx_data;
      3'd3:    w_rd_mux = r_tx_data;
      3'd4:    w_rd_mux = r_scratch;
      default: w_rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ctrl      <= 3'b000;
      r_scratch   <= 8'h00;
      r_rx_data   <= 8'h00;
      r_rx_avail  <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
      r_tx_done   <= 1'b0;
      r_out_data  <= 8'h00;
      r_prev_rd   <= 1'b0;
    end else begin
      r_prev_rd <= w_rd_acc;
      if (w_rd_acc)  r_out_data <= w_rd_mux;
      if (w_wr_ctrl) r_ctrl     <= in_data[2:0];
      if (w_wr_scr)  r_scratch  <= in_data;

      if (w_rx_load) begin
        r_rx_data  <= r_rx_shift;
        r_rx_avail <= 1'b1;
      end else if (w_rx_clear) begin
        r_rx_avail <= 1'b0;
      end

      if (w_rx_ovr)                        r_overrun   <= 1'b1;
      else if (w_wr_stat && in_data[2])    r_overrun   <= 1'b0;
      if (w_rx_ferr)                       r_frame_err <= 1'b1;
      else if (w_wr_stat && in_data[3])    r_frame_err <= 1'b0;
      if (w_tx_finish)                     r_tx_done   <= 1'b1;
      else if (w_tx_go || (w_wr_stat && in_data[4])) r_tx_done <= 1'b0;
    end
  end

  // ----------------------------------------------------------------- interrupts
  logic w_irq_err, w_irq_rx, w_irq_tx;

  assign w_irq_err = (r_overrun | r_frame_err) & r_ctrl[2];
  assign w_irq_rx  = r_rx_avail & r_ctrl[0];
  assign w_irq_tx  = r_tx_done & r_ctrl[1];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_irq    <= 1'b0;
      r_irq_id <= 3'd0;
    end else begin
      r_irq <= w_irq_err | w_irq_rx | w_irq_tx;
      if (w_irq_err)     r_irq_id <= 3'd1;
      else if (w_irq_rx) r_irq_id <= 3'd2;
      else if (w_irq_tx) r_irq_id <= 3'd3;
      else               r_irq_id <= 3'd0;
    end
  end

  assign out_data = r_out_data;
  assign irq      = r_irq;
  assign irq_id   = r_irq_id;

endmodule
`default_nettype wire

// File: tb/tb_uart_component.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_component
// Brief    : Directed self-checking bench for uart_component (BAUD_DIV = 16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_component;

  localparam int B = 16;

  logic       clock, reset, cs, rd, wr, rx_in;
  logic [2:0] addr;
  logic [7:0] in_data;
  logic [7:0] out_data;
  logic       tx_out, irq;
  logic [2:0] irq_id;

  int n_checks = 0;
  int n_fail   = 0;

  uart_component #(.BAUD_DIV(B)) dut (
    .clock   (clock),
    .reset   (reset),
    .cs      (cs),
    .rd      (rd),
    .wr      (wr),
    .addr    (addr),
    .in_data (in_data),
    .out_data(out_data),
    .rx_in   (rx_in),
    .tx_out  (tx_out),
    .irq     (irq),
    .irq_id  (irq_id)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0] a;
    logic [7:0] exp;
  } rd_vec_t;

  typedef struct {
    int   idx;
    logic line;
  } tx_vec_t;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", nm, act, exp);
    end
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
    @(negedge clock);
    cs = 1'b0; rd = 1'b0; addr = a;
    @(posedge clock); #1;
    d  = out_data;
    cs = 1'b1; rd = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [7:0] v);
    @(negedge clock);
    cs = 1'b0; wr = 1'b0; addr = a; in_data = v;
    @(posedge clock); #1;
    cs = 1'b1; wr = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    @(negedge clock);
    rx_in = 1'b0;
    repeat (B) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx_in = d[i];
      repeat (B) @(negedge clock);
    end
    rx_in = stop;
    repeat (B) @(negedge clock);
    rx_in = 1'b1;
    repeat (4) @(negedge clock);
  endtask

  rd_vec_t    reset_tab[8];
  tx_vec_t    tx_tab[10];
  logic [7:0] d;

  initial begin
    for (int i = 0; i < 8; i++) reset_tab[i] = '{a: 3'(i), exp: 8'h00};
    // 0xA5 framed: start, 1,0,1,0,0,1,0,1 (LSB first), stop
    tx_tab[0] = '{0, 1'b0}; tx_tab[1] = '{1, 1'b1}; tx_tab[2] = '{2, 1'b0};
    tx_tab[3] = '{3, 1'b1}; tx_tab[4] = '{4, 1'b0}; tx_tab[5] = '{5, 1'b0};
    tx_tab[6] = '{6, 1'b1}; tx_tab[7] = '{7, 1'b0}; tx_tab[8] = '{8, 1'b1};
    tx_tab[9] = '{9, 1'b1};

    reset = 1'b0; cs = 1'b1; rd = 1'b1; wr = 1'b1;
    addr = 3'd0; in_data = 8'h00; rx_in = 1'b1;
    repeat (3) @(negedge clock);
    chk("reset tx_out", {7'b0, tx_out}, 8'h01);
    chk("reset irq", {7'b0, irq}, 8'h00);
    chk("reset irq_id", {5'b0, irq_id}, 8'h00);
    chk("reset out_data", out_data, 8'h00);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    for (int i = 0; i < 8; i++) begin
      bus_read(reset_tab[i].a, d);
      chk($sformatf("reset read addr%0d", reset_tab[i].a), d, reset_tab[i].exp);
    end

    // Single byte received with RX_IE
    bus_write(3'd0, 8'h01);
    send_frame(8'h41, 1'b1);
    bus_read(3'd1, d);       chk("rx status", d, 8'h01);
    @(posedge clock); #1;
    chk("rx irq", {7'b0, irq}, 8'h01);
    chk("rx irq_id", {5'b0, irq_id}, 8'h02);
    bus_read(3'd2, d);       chk("rx data", d, 8'h41);
    bus_read(3'd1, d);       chk("rx status after read", d, 8'h00);
    @(posedge clock); #1;
    chk("rx irq cleared", {7'b0, irq}, 8'h00);

    // Overrun: second byte rejected
    bus_write(3'd0, 8'h05);
    send_frame(8'h41, 1'b1);
    send_frame(8'h42, 1'b1);
    bus_read(3'd1, d);       chk("ovr status", d, 8'h05);
    @(posedge clock); #1;
    chk("ovr irq_id", {5'b0, irq_id}, 8'h01);
    bus_read(3'd2, d);       chk("ovr rx data kept", d, 8'h41);
    bus_write(3'd1, 8'h04);
    bus_read(3'd1, d);       chk("ovr cleared", d, 8'h00);
    @(posedge clock); #1;
    chk("ovr irq cleared", {7'b0, irq}, 8'h00);

    // Transmit 0xA5; a write of 0x5A mid-frame must be ignored
    bus_write(3'd0, 8'h02);
    @(negedge clock);
    cs = 1'b0; wr = 1'b0; addr = 3'd3; in_data = 8'hA5;
    @(posedge clock); #1;
    cs = 1'b1; wr = 1'b1;
    repeat (1 + B / 2) @(posedge clock); #1;
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("tx bit%0d", tx_tab[k].idx), {7'b0, tx_out}, {7'b0, tx_tab[k].line});
      if (k == 3) begin
        cs = 1'b0; wr = 1'b0; addr = 3'd3; in_data = 8'h5A;
        @(posedge clock); #1;
        cs = 1'b1; wr = 1'b1;
        repeat (B - 1) @(posedge clock); #1;
      end else begin
        repeat (B) @(posedge clock); #1;
      end
    end
    bus_read(3'd1, d);       chk("tx done status", d, 8'h10);
    chk("tx irq", {7'b0, irq}, 8'h01);
    chk("tx irq_id", {5'b0, irq_id}, 8'h03);
    bus_read(3'd3, d);       chk("tx data kept", d, 8'hA5);
    bus_write(3'd1, 8'h10);
    bus_read(3'd1, d);       chk("tx done cleared", d, 8'h00);

    // Frame error: stop bit low
    send_frame(8'h33, 1'b0);
    bus_read(3'd1, d);       chk("ferr status", d, 8'h08);
    bus_write(3'd0, 8'hFF);
    bus_read(3'd0, d);       chk("ctrl readback", d, 8'h07);
    chk("ferr irq_id", {5'b0, irq_id}, 8'h01);
    bus_write(3'd1, 8'h08);
    bus_read(3'd1, d);       chk("ferr cleared", d, 8'h00);
    @(posedge clock); #1;
    chk("ferr irq cleared", {7'b0, irq}, 8'h00);

    // Short low glitch is rejected, then a real frame still lands
    @(negedge clock);
    rx_in = 1'b0;
    repeat (3) @(negedge clock);
    rx_in = 1'b1;
    repeat (3 * B) @(negedge clock);
    bus_read(3'd1, d);       chk("glitch status", d, 8'h00);
    send_frame(8'h3C, 1'b1);
    bus_read(3'd1, d);       chk("post-glitch status", d, 8'h01);
    bus_read(3'd2, d);       chk("post-glitch data", d, 8'h3C);

    // rd and wr low together: write wins, out_data holds
    bus_write(3'd4, 8'h5C);
    bus_read(3'd1, d);       chk("status before collision", d, 8'h00);
    @(negedge clock);
    cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = 3'd4; in_data = 8'h99;
    @(posedge clock); #1;
    cs = 1'b1; rd = 1'b1; wr = 1'b1;
    chk("collision out_data held", out_data, 8'h00);
    bus_read(3'd4, d);       chk("collision scratch", d, 8'h99);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
